// File: rtl/idli_sqi_arb_m_if.sv
// idli_sqi_arb_m_if: request/grant and SQI nibble bus between core requesters, arbiter and SQI controller
// slave modport: arbiter view (requests and memory nibbles in, grants/done/read word/nibbles out)
// master modport: core/controller view (the mirror image)
interface idli_sqi_arb_m_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         i_arb_f_req;
  logic [W-1:0] i_arb_f_addr;
  logic         o_arb_f_gnt;
  logic         o_arb_f_done;
  logic         i_arb_d_req;
  logic         i_arb_d_wr;
  logic [W-1:0] i_arb_d_addr;
  logic [W-1:0] i_arb_d_wdata;
  logic         o_arb_d_gnt;
  logic         o_arb_d_done;
  logic [W-1:0] o_arb_rdata;
  logic         o_arb_mem_busy;
  logic         o_arb_mem_rd;
  logic [3:0]   o_arb_mem_data;
  logic [3:0]   i_arb_mem_data;
  logic         i_arb_mem_step;
  modport slave (
    input  i_arb_f_req, i_arb_f_addr, i_arb_d_req, i_arb_d_wr, i_arb_d_addr, i_arb_d_wdata,
           i_arb_mem_data, i_arb_mem_step,
    output o_arb_f_gnt, o_arb_f_done, o_arb_d_gnt, o_arb_d_done, o_arb_rdata,
           o_arb_mem_busy, o_arb_mem_rd, o_arb_mem_data
  );
  modport master (
    output i_arb_f_req, i_arb_f_addr, i_arb_d_req, i_arb_d_wr, i_arb_d_addr, i_arb_d_wdata,
           i_arb_mem_data, i_arb_mem_step,
    input  o_arb_f_gnt, o_arb_f_done, o_arb_d_gnt, o_arb_d_done, o_arb_rdata,
           o_arb_mem_busy, o_arb_mem_rd, o_arb_mem_data
  );
endinterface

// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: arbitrates fetch/data requesters onto the SQI port and sequences address and data nibbles
// i_arb_gck: core clock; i_arb_rst: asynchronous active-high reset
// arb: request/grant/done per requester, shared read word, nibble bus to the SQI controller
module idli_sqi_arb_m #(
  parameter bit DATA_PRIO = 1'b0,
  parameter int NIBBLES   = 4
) (
  input logic              i_arb_gck,
  input logic              i_arb_rst,
  idli_sqi_arb_m_if.slave  arb
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3;
  logic [1:0]    state;
  logic          own_d;
  logic          last_d;
  logic          wr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sh;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          pick_d;
  logic          busy;
  logic          step_last;
  // D wins a tie under data priority, otherwise whoever was not served last
  assign pick_d    = arb.i_arb_d_req & (~arb.i_arb_f_req | DATA_PRIO | ~last_d);
  assign step_last = arb.i_arb_mem_step & (cnt == LAST);
  // sh holds the outgoing nibbles MSB-first: address first, then write data
  always_ff @(posedge i_arb_gck or posedge i_arb_rst) begin
    if (i_arb_rst) begin
      state  <= IDLE;
      own_d  <= 1'b0;
      last_d <= 1'b1;
      wr     <= 1'b0;
      cnt    <= '0;
      sh     <= '0;
      wdata  <= '0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (arb.i_arb_f_req | arb.i_arb_d_req) begin
          state <= ADDR;
          own_d <= pick_d;
          wr    <= pick_d & arb.i_arb_d_wr;
          sh    <= pick_d ? arb.i_arb_d_addr : arb.i_arb_f_addr;
          wdata <= arb.i_arb_d_wdata;
          cnt   <= '0;
        end
        ADDR: if (arb.i_arb_mem_step) begin
          cnt   <= step_last ? '0 : cnt + 1'b1;
          sh    <= step_last ? wdata : sh << 4;
          state <= step_last ? DATA : ADDR;
        end
        DATA: if (arb.i_arb_mem_step) begin
          cnt   <= step_last ? '0 : cnt + 1'b1;
          sh    <= sh << 4;
          rdata <= wr ? rdata : W'({rdata, arb.i_arb_mem_data});
          state <= step_last ? DONE : DATA;
        end
        DONE: begin
          last_d <= own_d;
          state  <= IDLE;
        end
      endcase
    end
  end
  assign busy               = state != IDLE;
  assign arb.o_arb_mem_busy = busy;
  assign arb.o_arb_f_gnt    = busy & ~own_d;
  assign arb.o_arb_d_gnt    = busy & own_d;
  assign arb.o_arb_f_done   = (state == DONE) & ~own_d;
  assign arb.o_arb_d_done   = (state == DONE) & own_d;
  assign arb.o_arb_mem_rd   = busy & ~wr;
  assign arb.o_arb_mem_data = (state == ADDR || (state == DATA && wr)) ? sh[W-1 -: 4] : 4'h0;
  assign arb.o_arb_rdata    = rdata;
endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// tb_idli_sqi_arb_m: round-robin and data-priority arbiters side by side against a transaction-level model
module tb_idli_sqi_arb_m;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        f_req [2];
  logic        d_req [2];
  logic        d_wr [2];
  logic [15:0] f_addr [2];
  logic [15:0] d_addr [2];
  logic [15:0] d_wdata [2];
  logic        mem_step;
  logic [3:0]  mem_in;
  logic        o_fg [2];
  logic        o_fd [2];
  logic        o_dg [2];
  logic        o_dd [2];
  logic        o_busy [2];
  logic        o_mrd [2];
  logic [3:0]  o_md [2];
  logic [15:0] o_rd [2];
  idli_sqi_arb_m_if #(.NIBBLES(NB)) ifs [2] ();
  for (genvar g = 0; g < 2; g++) begin : g_dut
    idli_sqi_arb_m #(.DATA_PRIO(g == 1), .NIBBLES(NB)) dut (
      .i_arb_gck (clk),
      .i_arb_rst (rst),
      .arb       (ifs[g])
    );
    assign ifs[g].i_arb_f_req    = f_req[g];
    assign ifs[g].i_arb_f_addr   = f_addr[g];
    assign ifs[g].i_arb_d_req    = d_req[g];
    assign ifs[g].i_arb_d_wr     = d_wr[g];
    assign ifs[g].i_arb_d_addr   = d_addr[g];
    assign ifs[g].i_arb_d_wdata  = d_wdata[g];
    assign ifs[g].i_arb_mem_data = mem_in;
    assign ifs[g].i_arb_mem_step = mem_step;
    assign o_fg[g]   = ifs[g].o_arb_f_gnt;
    assign o_fd[g]   = ifs[g].o_arb_f_done;
    assign o_dg[g]   = ifs[g].o_arb_d_gnt;
    assign o_dd[g]   = ifs[g].o_arb_d_done;
    assign o_busy[g] = ifs[g].o_arb_mem_busy;
    assign o_mrd[g]  = ifs[g].o_arb_mem_rd;
    assign o_md[g]   = ifs[g].o_arb_mem_data;
    assign o_rd[g]   = ifs[g].o_arb_rdata;
  end
  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Transaction model: n counts accepted steps, 0..NB-1 address, NB..2NB-1 data, 2NB = done cycle
  bit          m_act [2];
  bit          m_own [2];
  bit          m_wr [2];
  bit          m_last [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd [2];
  logic [15:0] m_rd [2];
  int          m_n [2];
  always @(posedge clk or posedge rst) begin
    bit own;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        m_act[p]  <= 1'b0;
        m_last[p] <= 1'b1;
        m_rd[p]   <= 16'h0;
        m_n[p]    <= 0;
      end else if (!m_act[p]) begin
        if (f_req[p] || d_req[p]) begin
          own = d_req[p] && (!f_req[p] || p == 1 || !m_last[p]);
          m_act[p]  <= 1'b1;
          m_own[p]  <= own;
          m_wr[p]   <= own && d_wr[p];
          m_addr[p] <= own ? d_addr[p] : f_addr[p];
          m_wd[p]   <= d_wdata[p];
          m_n[p]    <= 0;
        end
      end else if (m_n[p] == 2 * NB) begin
        m_act[p]  <= 1'b0;
        m_last[p] <= m_own[p];
      end else if (mem_step) begin
        if (m_n[p] >= NB && !m_wr[p]) m_rd[p] <= 16'((m_rd[p] * 16) + mem_in);
        m_n[p] <= m_n[p] + 1;
      end
    end
  end
  function automatic logic [25:0] exp_out(input int p);
    logic [3:0] md;
    bit dn;
    md = 4'h0;
    dn = m_act[p] && m_n[p] == 2 * NB;
    if (m_act[p] && m_n[p] < NB) md = 4'(m_addr[p] >> (4 * (NB - 1 - m_n[p])));
    else if (m_act[p] && m_n[p] < 2 * NB && m_wr[p]) md = 4'(m_wd[p] >> (4 * (2 * NB - 1 - m_n[p])));
    return {m_act[p], m_act[p] && !m_own[p], m_act[p] && m_own[p], dn && !m_own[p], dn && m_own[p],
            m_act[p] && !m_wr[p], md, m_rd[p]};
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++)
        chk($sformatf("model_p%0d", p),
            {6'h0, o_busy[p], o_fg[p], o_dg[p], o_fd[p], o_dd[p], o_mrd[p], o_md[p], o_rd[p]},
            {6'h0, exp_out(p)});
    end
  end
  typedef struct {
    logic        f;
    logic        d;
    logic        wr;
    logic [15:0] fa;
    logic [15:0] da;
    logic [15:0] wd;
    logic [15:0] mem;
    int          per;
    logic        ed0;
    logic        ed1;
    logic [15:0] er0;
    logic [15:0] er1;
    logic [31:0] emd;
  } vec_t;
  // Caller sits on a negedge with both arbiters idle; emd is the nibble stream DUT0 puts out on its steps
  task automatic run_x(input vec_t v, input int stall_n, input int stop_n);
    logic [31:0] cap;
    bit fin;
    bit st;
    cap = 32'h0;
    fin = 1'b0;
    for (int p = 0; p < 2; p++) begin
      f_req[p] = v.f; d_req[p] = v.d; d_wr[p] = v.wr;
      f_addr[p] = v.fa; d_addr[p] = v.da; d_wdata[p] = v.wd;
    end
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("gnt_p0", {o_dg[0], o_fg[0]}, {v.ed0, !v.ed0});
        chk("gnt_p1", {o_dg[1], o_fg[1]}, {v.ed1, !v.ed1});
      end
      if (stop_n >= 0 && m_act[0] && m_n[0] == stop_n) begin
        mem_step = 1'b0;
        return;
      end
      if (m_act[0] && m_n[0] == 2 * NB) begin
        chk("done_p0", {o_dd[0], o_fd[0]}, {v.ed0, !v.ed0});
        chk("done_p1", {o_dd[1], o_fd[1]}, {v.ed1, !v.ed1});
        chk("rdata_p0", o_rd[0], v.er0);
        chk("rdata_p1", o_rd[1], v.er1);
        chk("nibbles_p0", cap, v.emd);
        for (int p = 0; p < 2; p++) begin
          f_req[p] = 1'b0;
          d_req[p] = 1'b0;
        end
        mem_step = 1'b0;
        fin = 1'b1;
      end else begin
        if (stall_n >= 0 && m_act[0] && m_n[0] == stall_n) begin
          mem_step = 1'b0;
          repeat (10) begin
            @(negedge clk);
            chk("stall_gnt_p0", {o_dg[0], o_fg[0]}, {v.ed0, !v.ed0});
          end
          stall_n = -1;
        end
        st = (c % v.per) == (v.per - 1);
        if (st && m_act[0] && m_n[0] < 2 * NB) cap = {cap[27:0], o_md[0]};
        mem_step = st;
        mem_in = (m_act[0] && m_n[0] >= NB && m_n[0] < 2 * NB) ?
                 4'(v.mem >> (4 * (2 * NB - 1 - m_n[0]))) : 4'h0;
      end
    end
    chk("done_seen", {31'h0, fin}, 32'h1);
  endtask
  vec_t tv [8];
  vec_t dv;
  initial begin
    for (int p = 0; p < 2; p++) begin
      f_req[p] = 1'b0; d_req[p] = 1'b0; d_wr[p] = 1'b0;
      f_addr[p] = 16'h0; d_addr[p] = 16'h0; d_wdata[p] = 16'h0;
    end
    mem_step = 1'b0;
    mem_in = 4'h0;
    tv[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'hABCD, 1, 1'b0, 1'b0, 16'hABCD, 16'hABCD, 32'h12340000};
    tv[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h00F0, 16'hBEEF, 16'h0000, 2, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 32'h00F0BEEF};
    tv[2] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h5A5A, 1, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A, 32'h11110000};
    tv[3] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h0F0F, 3, 1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 32'h22220000};
    tv[4] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h1357, 1, 1'b0, 1'b1, 16'h1357, 16'h1357, 32'h11110000};
    tv[5] = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'hCAFE, 16'h0000, 1, 1'b1, 1'b1, 16'h1357, 16'h1357, 32'h2222CAFE};
    tv[6] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h2222, 16'h0000, 16'h0000, 2, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'hFFFF0000};
    tv[7] = '{1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h8421, 1, 1'b1, 1'b1, 16'h8421, 16'h8421, 32'h22220000};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_p0", {o_busy[0], o_fg[0], o_dg[0], o_fd[0], o_dd[0], o_mrd[0], o_md[0], o_rd[0]}, 32'h0);
    chk("reset_p1", {o_busy[1], o_fg[1], o_dg[1], o_fd[1], o_dd[1], o_mrd[1], o_md[1], o_rd[1]}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("gap_p0", {31'h0, o_busy[0]}, 32'h0);
      run_x(tv[i], -1, -1);
    end
    @(negedge clk);
    dv = '{1'b1, 1'b0, 1'b0, 16'h9C5E, 16'h0000, 16'h0000, 16'h3C3C, 1, 1'b0, 1'b0, 16'h3C3C, 16'h3C3C, 32'h9C5E0000};
    run_x(dv, 2, -1);
    @(negedge clk);
    dv = '{1'b1, 1'b0, 1'b0, 16'hA5C3, 16'h0000, 16'h0000, 16'h7777, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0};
    run_x(dv, -1, NB + 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_p0", {o_busy[0], o_fg[0], o_dg[0], o_fd[0], o_dd[0], o_mrd[0], o_md[0], o_rd[0]}, 32'h0);
    chk("async_rst_p1", {o_busy[1], o_fg[1], o_dg[1], o_fd[1], o_dd[1], o_mrd[1], o_md[1], o_rd[1]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dv = '{1'b1, 1'b0, 1'b0, 16'h4321, 16'h0000, 16'h0000, 16'h6789, 1, 1'b0, 1'b0, 16'h6789, 16'h6789, 32'h43210000};
    run_x(dv, -1, -1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (m_act[p] && m_n[p] == 2 * NB) begin
          if (m_own[p]) d_req[p] = 1'($urandom);
          else f_req[p] = 1'($urandom);
        end else begin
          if (!f_req[p] && $urandom_range(3) == 0) begin
            f_req[p] = 1'b1;
            f_addr[p] = 16'($urandom);
          end
          if (!d_req[p] && $urandom_range(3) == 0) begin
            d_req[p] = 1'b1;
            d_wr[p] = 1'($urandom);
            d_addr[p] = 16'($urandom);
            d_wdata[p] = 16'($urandom);
          end
          if (m_act[p] && $urandom_range(63) == 0) begin
            if (m_own[p]) d_req[p] = 1'b0;
            else f_req[p] = 1'b0;
          end
        end
      end
      mem_step = $urandom_range(2) != 0;
      mem_in = 4'($urandom);
    end
    for (int p = 0; p < 2; p++) begin
      f_req[p] = 1'b0;
      d_req[p] = 1'b0;
    end
    mem_step = 1'b1;
    for (int c = 0; c < 40 && (m_act[0] || m_act[1]); c++) @(negedge clk);
    @(negedge clk);
    chk("drain", {30'h0, o_busy[1], o_busy[0]}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
